ysyx_24070014_ifu: RTL and testbench
====================================

Name: ysyx_24070014_ifu

Overview:
Instruction fetch unit, directly upstream of the decode stage that drives the immediate generator's `inst` input. Owns the PC and issues one request at a time to instruction memory over a valid/ready request channel plus a valid-only response channel. Holds each fetched instruction with its PC until decode accepts it. Handles redirects from branch/jump resolution, including discarding a response already in flight.

Parameters:
WORD_LEN, 32, width of PC and memory address (32 for RV32, 64 for RV64)
RESET_PC, 32'h8000_0000, PC of the first fetch after reset (zero-extended to WORD_LEN)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts the request this cycle
imem_req_addr  out  WORD_LEN  fetch address; always equals the current PC
imem_resp_valid  in  1  response valid; arrives at least 1 cycle after request acceptance
imem_resp_data  in  32  fetched instruction word
imem_resp_err  in  1  access fault for this response
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts the instruction
out_inst  out  32  instruction word; feeds decode/immediate generation
out_pc  out  WORD_LEN  PC of out_inst
out_fault  out  1  out_inst came from a faulting access; treat as invalid encoding
redirect_valid  in  1  redirect the fetch stream
redirect_pc  in  WORD_LEN  new PC; bits [1:0] forced to 0 on capture

Behaviour:
- States: REQ, WAIT, HOLD. Registers: pc, state, discard, inst_q, fault_q.
- Reset (rst high at an edge): state=REQ, pc=RESET_PC, discard=0, inst_q=0, fault_q=0. While rst is high, imem_req_valid=0 and out_valid=0. Outputs are combinational from state, so the first request is asserted in the first cycle after reset deasserts.
- imem_req_valid = (state==REQ) && !rst. imem_req_addr = pc.
- out_valid = (state==HOLD) && !redirect_valid && !rst. out_inst=inst_q, out_pc=pc, out_fault=fault_q.
- REQ:
  - on imem_req_ready → WAIT.
  - The address may change while un-accepted only because of a redirect.
- WAIT:
  - on imem_resp_valid with discard=0: inst_q<=resp_data, fault_q<=resp_err → HOLD.
  - with discard=1: drop the response, discard<=0 → REQ.
- HOLD:
  - on out_valid && out_ready: pc<=pc+4 (mod 2^WORD_LEN, wraps silently) → REQ.
  - Otherwise hold all outputs stable.
- Redirect has priority over every other event in the same cycle. pc<=redirect_pc & ~3.
  - REQ without accept: stay REQ.
  - REQ with accept in the same cycle: → WAIT, discard<=1.
  - WAIT without resp_valid: stay WAIT, discard<=1.
  - WAIT with resp_valid in the same cycle: response dropped → REQ, discard<=0.
  - HOLD: held instruction dropped (out_valid already gated low, so no handshake occurs) → REQ.
  - A second redirect while discard=1 only updates pc.
- imem_resp_valid outside WAIT is ignored. At most one request is outstanding.
- Minimum latency with zero-wait memory:
  - cycle n: request accepted.
  - cycle n+1: response.
  - cycle n+2: out_valid.
  - Peak throughput: one instruction per 3 cycles when out_ready is held high.
- rst asserted mid-transaction: state returns to REQ/RESET_PC. A response arriving after reset is ignored because state is not WAIT. Memory must drop pending work on the same rst.

Test Plan:
- Reset release, ready/resp always 1 → req addrs 0x80000000, 0x80000004, 0x80000008. out_pc matches each addr. out_valid pulses every 3rd cycle. out_inst equals resp_data.
- Decode stall: out_ready=0 for 5 cycles in HOLD → out_valid, out_inst and out_pc stable. imem_req_valid=0 throughout. pc advances by 4 only on the accepting cycle.
- Redirect in WAIT to 0x80001002 → the current response (e.g. 0x00000013) is never presented. The next request address is 0x80001000.
- Redirect in HOLD, same cycle as out_ready=1 → out_valid low that cycle, no handshake. The next request address is the redirect target.
- Redirect in the same cycle as resp_valid, and in the same cycle as req accept → the response is discarded in both cases. In the accept case, exactly one later response is dropped and the following one is delivered with out_pc equal to the target.
- imem_resp_err=1 at pc 0x80000010 → out_fault=1 with out_pc=0x80000010. Then rst pulsed mid-WAIT → next req addr 0x80000000 and no stale out_valid.

Source files
------------

// File: rtl/ysyx_24070014_ifu_if.sv
// Fetch unit bus bundle: instruction-memory request/response channels,
// the decode-side handoff and the redirect input.
interface ysyx_24070014_ifu_if #(
    parameter int WORD_LEN = 32
);
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [WORD_LEN-1:0] imem_req_addr;
    logic                imem_resp_valid;
    logic [31:0]         imem_resp_data;
    logic                imem_resp_err;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_inst;
    logic [WORD_LEN-1:0] out_pc;
    logic                out_fault;
    logic                redirect_valid;
    logic [WORD_LEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  imem_resp_err,
        output out_valid,
        output out_inst,
        output out_pc,
        output out_fault,
        input  out_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output imem_resp_err,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        input  out_fault,
        output out_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/ysyx_24070014_ifu.sv
// Instruction fetch unit: owns the PC, keeps one fetch outstanding and
// holds the fetched word until decode takes it; handles redirects.
module ysyx_24070014_ifu #(
    parameter int                  WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC = WORD_LEN'(32'h8000_0000)
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_24070014_ifu_if.master        bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_LEN-1:0] pc_q, pc_d;
    logic                discard_q, discard_d;
    logic [31:0]         inst_q, inst_d;
    logic                fault_q, fault_d;
    logic [WORD_LEN-1:0] redir_pc;
    logic                req_fire;
    logic                out_fire;

    assign redir_pc = {bus.redirect_pc[WORD_LEN-1:2], 2'b00};

    // Redirect masks out_valid so a redirected HOLD never handshakes
    assign bus.imem_req_valid = (state_q == S_REQ) && !rst;
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = (state_q == S_HOLD) && !bus.redirect_valid && !rst;
    assign bus.out_inst       = inst_q;
    assign bus.out_pc         = pc_q;
    assign bus.out_fault      = fault_q;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        inst_d    = inst_q;
        fault_d   = fault_q;
        case (state_q)
            S_REQ: begin
                if (bus.redirect_valid) begin
                    pc_d = redir_pc;
                end
                // A request accepted alongside a redirect fetched the old PC
                if (req_fire) begin
                    state_d   = S_WAIT;
                    discard_d = bus.redirect_valid;
                end
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d = redir_pc;
                    if (bus.imem_resp_valid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (bus.imem_resp_valid) begin
                    if (discard_q) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        state_d = S_HOLD;
                        inst_d  = bus.imem_resp_data;
                        fault_d = bus.imem_resp_err;
                    end
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = S_REQ;
                end else if (out_fire) begin
                    pc_d    = pc_q + WORD_LEN'(4);
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            inst_q    <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            inst_q    <= inst_d;
            fault_q   <= fault_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24070014_ifu.sv
// Bench for the fetch unit: directed scenarios, then random traffic
// checked against a fetch-stream model with an address-derived memory.
module tb_ysyx_24070014_ifu;

    localparam int          W      = 32;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_24070014_ifu_if #(.WORD_LEN(W)) bus ();

    ysyx_24070014_ifu #(
        .WORD_LEN(W),
        .RESET_PC(RST_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    bit          k_rst, k_req_ready, k_out_ready, k_redir;
    logic [31:0] k_redir_pc;
    int          k_lat;
    int          k_spur;

    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt;

    logic [31:0] exp_pc;
    bit          prev_hold;
    logic [31:0] prev_pc, prev_inst;
    logic        prev_fault;
    int          deliveries;

    logic        s_req_valid, s_out_valid, s_out_fault;
    logic [31:0] s_req_addr, s_out_pc, s_out_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[4:2] == 3'b100;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        bit resp_real;
        @(negedge clk);
        rst                = k_rst;
        bus.imem_req_ready = k_req_ready;
        bus.out_ready      = k_out_ready;
        bus.redirect_valid = k_redir;
        bus.redirect_pc    = k_redir_pc;
        resp_real = pend && (pend_cnt == 0);
        if (resp_real) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(pend_addr);
            bus.imem_resp_err   = mem_err(pend_addr);
        end else if (!pend && (k_spur == 1 ||
                     (k_spur == 2 && $urandom_range(0, 3) == 0))) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = $urandom;
            bus.imem_resp_err   = 1'($urandom_range(0, 1));
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom;
            bus.imem_resp_err   = 1'b0;
        end
        #1;
        s_req_valid = bus.imem_req_valid;
        s_req_addr  = bus.imem_req_addr;
        s_out_valid = bus.out_valid;
        s_out_pc    = bus.out_pc;
        s_out_inst  = bus.out_inst;
        s_out_fault = bus.out_fault;
        if (k_rst) begin
            chk("rst_req_valid", 64'(s_req_valid), 64'd0);
            chk("rst_out_valid", 64'(s_out_valid), 64'd0);
        end else begin
            if (s_req_valid) chk("req_addr", 64'(s_req_addr), 64'(exp_pc));
            chk("req_out_excl", 64'(s_req_valid && s_out_valid), 64'd0);
            if (k_redir) chk("redir_gates_out", 64'(s_out_valid), 64'd0);
            if (s_out_valid) begin
                chk("out_pc", 64'(s_out_pc), 64'(exp_pc));
                chk("out_inst", 64'(s_out_inst), 64'(mem_word(exp_pc)));
                chk("out_fault", 64'(s_out_fault), 64'(mem_err(exp_pc)));
            end
            if (prev_hold && !k_redir) begin
                chk("hold_valid", 64'(s_out_valid), 64'd1);
                chk("hold_pc", 64'(s_out_pc), 64'(prev_pc));
                chk("hold_inst", 64'(s_out_inst), 64'(prev_inst));
                chk("hold_fault", 64'(s_out_fault), 64'(prev_fault));
            end
            if (s_req_valid && k_req_ready)
                chk("one_outstanding", 64'(pend && !resp_real), 64'd0);
        end
        if (k_rst) begin
            exp_pc    = RST_PC;
            pend      = 1'b0;
            prev_hold = 1'b0;
        end else begin
            prev_hold  = s_out_valid && !k_out_ready;
            prev_pc    = s_out_pc;
            prev_inst  = s_out_inst;
            prev_fault = s_out_fault;
            if (k_redir) exp_pc = k_redir_pc & ~32'd3;
            else if (s_out_valid && k_out_ready) begin
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            if (resp_real) pend = 1'b0;
            else if (pend) pend_cnt--;
            if (s_req_valid && k_req_ready) begin
                pend      = 1'b1;
                pend_addr = s_req_addr;
                pend_cnt  = k_lat;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        k_rst = 1; k_req_ready = 1; k_out_ready = 1; k_redir = 0;
        k_redir_pc = 32'd0; k_lat = 0; k_spur = 0;
        pend = 0; pend_addr = 0; pend_cnt = 0;
        exp_pc = RST_PC; prev_hold = 0; deliveries = 0;
        prev_pc = 0; prev_inst = 0; prev_fault = 0;
        bus.imem_req_ready = 0; bus.imem_resp_valid = 0;
        bus.imem_resp_data = 0; bus.imem_resp_err = 0;
        bus.out_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;

        tick(); tick();
        k_rst = 0;

        // zero-wait stream: one instruction every third cycle
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stream_req", 64'(s_req_valid), 64'd1);
            chk("stream_addr", 64'(s_req_addr), 64'(RST_PC + 32'(4 * i)));
            tick();
            chk("stream_gap", 64'(s_out_valid), 64'd0);
            tick();
            chk("stream_out", 64'(s_out_valid), 64'd1);
            chk("stream_pc", 64'(s_out_pc), 64'(RST_PC + 32'(4 * i)));
            chk("stream_inst", 64'(s_out_inst),
                64'(mem_word(RST_PC + 32'(4 * i))));
        end

        // decode stall for five cycles
        tick(); tick();
        k_out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 64'(s_out_valid), 64'd1);
            chk("stall_noreq", 64'(s_req_valid), 64'd0);
            chk("stall_pc", 64'(s_out_pc), 64'(RST_PC + 32'd12));
        end
        k_out_ready = 1;
        tick();
        chk("stall_release", 64'(s_out_valid), 64'd1);

        // redirect while waiting, response not yet back
        k_lat = 2;
        tick();
        chk("wait_req", 64'(s_req_addr), 64'(RST_PC + 32'd16));
        k_redir = 1; k_redir_pc = 32'h8000_1002;
        tick();
        k_redir = 0;
        tick(); tick();
        chk("wait_drop", 64'(s_out_valid), 64'd0);
        k_lat = 0;
        tick();
        chk("wait_target", 64'(s_req_valid ? s_req_addr : 32'd0),
            64'h8000_1000);
        tick();

        // redirect in HOLD with decode ready
        k_redir = 1; k_redir_pc = 32'h8000_2000;
        tick();
        chk("hold_redir_nohs", 64'(s_out_valid), 64'd0);
        k_redir = 0;
        tick();
        chk("hold_redir_req", 64'(s_req_valid ? s_req_addr : 32'd0),
            64'h8000_2000);

        // redirect coincident with response, then with accept
        k_redir = 1; k_redir_pc = 32'h8000_3000;
        tick();
        k_redir_pc = 32'h8000_4000;
        tick();
        chk("acc_redir_req", 64'(s_req_valid ? s_req_addr : 32'd0),
            64'h8000_3000);
        k_redir = 0;
        tick();
        chk("acc_drop", 64'(s_out_valid), 64'd0);
        tick();
        chk("acc_target_req", 64'(s_req_valid ? s_req_addr : 32'd0),
            64'h8000_4000);
        tick();
        tick();
        chk("acc_target_out", 64'(s_out_valid ? s_out_pc : 32'd0),
            64'h8000_4000);

        // access fault, then reset in the middle of a wait
        k_redir = 1; k_redir_pc = 32'h8000_0010; k_req_ready = 0;
        tick();
        k_redir = 0; k_req_ready = 1;
        tick(); tick(); tick();
        chk("fault_flag", 64'(s_out_valid && s_out_fault), 64'd1);
        chk("fault_pc", 64'(s_out_pc), 64'h8000_0010);
        k_lat = 3;
        tick();
        tick();
        k_rst = 1;
        tick();
        k_rst = 0; k_req_ready = 0; k_spur = 1; k_lat = 0;
        tick();
        chk("rst_req_addr", 64'(s_req_valid ? s_req_addr : 32'd0),
            64'(RST_PC));
        tick();
        chk("rst_no_stale", 64'(s_out_valid), 64'd0);
        k_spur = 0; k_req_ready = 1;
        tick();
        chk("rst_still_req", 64'(s_req_valid), 64'd1);
        tick(); tick();
        chk("rst_first_out", 64'(s_out_valid ? s_out_pc : 32'd0),
            64'(RST_PC));

        // random traffic against the stream model
        deliveries = 0;
        k_spur = 2;
        for (int c = 0; c < 1500; c++) begin
            k_rst       = ($urandom_range(0, 199) == 0);
            k_req_ready = 1'($urandom_range(0, 1));
            k_out_ready = ($urandom_range(0, 9) < 6);
            k_redir     = ($urandom_range(0, 19) == 0);
            k_redir_pc  = RST_PC + 32'($urandom_range(0, 255) << 2)
                          + 32'($urandom_range(0, 3));
            k_lat       = $urandom_range(0, 2);
            tick();
        end
        chk("progress", 64'(deliveries >= 40), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
